avalon_arbiter_2m: RTL

//  Shares one Avalon-MM slave (variable-wait, waitrequest + readdatavalid) between two

---
 rtl/avalon_arbiter_2m_if.sv | 52 +++++
 rtl/avalon_arbiter_2m.sv | 119 +++++++++++
 2 files changed

// File: rtl/avalon_arbiter_2m_if.sv
// Bus bundle between two Avalon-MM masters, the 2:1 arbiter and the shared slave.
// "slave" modport is the arbiter's view; "master" modport is the surrounding environment's view.
interface avalon_arbiter_2m_if #(
    parameter int NBDATABYTES = 2,
    parameter int NBADDRBITS  = 8
);
    localparam int DW = 8 * NBDATABYTES;

    logic [NBADDRBITS-1:0]  m0_address,    m1_address;
    logic [NBDATABYTES-1:0] m0_byteenable, m1_byteenable;
    logic                   m0_read,       m1_read;
    logic                   m0_write,      m1_write;
    logic [DW-1:0]          m0_writedata,  m1_writedata;
    logic                   m0_waitrequest,   m1_waitrequest;
    logic [DW-1:0]          m0_readdata,      m1_readdata;
    logic                   m0_readdatavalid, m1_readdatavalid;

    logic [NBADDRBITS-1:0]  s_address;
    logic [NBDATABYTES-1:0] s_byteenable;
    logic [DW-1:0]          s_writedata;
    logic                   s_read;
    logic                   s_write;
    logic [DW-1:0]          s_readdata;
    logic                   s_readdatavalid;
    logic                   s_waitrequest;

    logic [1:0]             grant;
    logic                   err;
    logic                   err_clr;

    modport slave (
        input  m0_address, m0_byteenable, m0_read, m0_write, m0_writedata,
        input  m1_address, m1_byteenable, m1_read, m1_write, m1_writedata,
        output m0_waitrequest, m0_readdata, m0_readdatavalid,
        output m1_waitrequest, m1_readdata, m1_readdatavalid,
        output s_address, s_byteenable, s_writedata, s_read, s_write,
        input  s_readdata, s_readdatavalid, s_waitrequest,
        output grant, err,
        input  err_clr
    );

    modport master (
        output m0_address, m0_byteenable, m0_read, m0_write, m0_writedata,
        output m1_address, m1_byteenable, m1_read, m1_write, m1_writedata,
        input  m0_waitrequest, m0_readdata, m0_readdatavalid,
        input  m1_waitrequest, m1_readdata, m1_readdatavalid,
        input  s_address, s_byteenable, s_writedata, s_read, s_write,
        output s_readdata, s_readdatavalid, s_waitrequest,
        input  grant, err,
        output err_clr
    );
endinterface

// File: rtl/avalon_arbiter_2m.sv
// Round-robin 2:1 Avalon-MM arbiter, one outstanding transaction; 1-cycle arbitration then command pass-through.
// Non-owners see waitrequest=1 until served; reads release on readdatavalid or after TIMEOUT RD_WAIT cycles.
module avalon_arbiter_2m #(
    parameter int NBDATABYTES = 2,
    parameter int NBADDRBITS  = 8,
    parameter int TIMEOUT     = 16
) (
    input  logic                clk,
    input  logic                rst,
    avalon_arbiter_2m_if.slave  bus
);
    localparam int DW = 8 * NBDATABYTES;
    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_CMD     = 2'd1;
    localparam logic [1:0] ST_RD_WAIT = 2'd2;

    logic [1:0]    r_state;
    logic          r_owner;
    logic          r_last;
    logic          r_err;
    logic [CW-1:0] r_cnt;

    logic                   w_req0, w_req1, w_winner;
    logic                   w_cmd, w_rdw, w_busy;
    logic                   w_own_rd, w_own_wr, w_own_req;
    logic [NBADDRBITS-1:0]  w_own_addr;
    logic [NBDATABYTES-1:0] w_own_be;
    logic [DW-1:0]          w_own_wdat;
    logic                   w_timeout;
    logic                   w_err_set;

    // Read and write together is malformed and never counts as a request.
    assign w_req0   = bus.m0_read ^ bus.m0_write;
    assign w_req1   = bus.m1_read ^ bus.m1_write;
    assign w_winner = (w_req0 & w_req1) ? ~r_last : w_req1;

    assign w_cmd  = (r_state == ST_CMD);
    assign w_rdw  = (r_state == ST_RD_WAIT);
    assign w_busy = w_cmd | w_rdw;

    assign w_own_rd   = r_owner ? (bus.m1_read & ~bus.m1_write) : (bus.m0_read & ~bus.m0_write);
    assign w_own_wr   = r_owner ? (bus.m1_write & ~bus.m1_read) : (bus.m0_write & ~bus.m0_read);
    assign w_own_req  = w_own_rd | w_own_wr;
    assign w_own_addr = r_owner ? bus.m1_address    : bus.m0_address;
    assign w_own_be   = r_owner ? bus.m1_byteenable : bus.m0_byteenable;
    assign w_own_wdat = r_owner ? bus.m1_writedata  : bus.m0_writedata;

    assign w_timeout = w_rdw & ~bus.s_readdatavalid & (r_cnt == CW'(TIMEOUT - 1));

    assign w_err_set = (bus.m0_read & bus.m0_write) | (bus.m1_read & bus.m1_write)
                     | ((r_state == ST_IDLE) & bus.s_readdatavalid)
                     | (w_cmd & ~w_own_req)
                     | w_timeout;

    assign bus.s_read       = w_cmd & w_own_rd;
    assign bus.s_write      = w_cmd & w_own_wr;
    assign bus.s_address    = w_cmd ? w_own_addr : '0;
    assign bus.s_byteenable = w_cmd ? w_own_be   : '0;
    assign bus.s_writedata  = w_cmd ? w_own_wdat : '0;

    assign bus.m0_waitrequest   = (w_cmd & ~r_owner) ? bus.s_waitrequest : 1'b1;
    assign bus.m1_waitrequest   = (w_cmd &  r_owner) ? bus.s_waitrequest : 1'b1;
    assign bus.m0_readdatavalid = bus.s_readdatavalid & w_busy & ~r_owner;
    assign bus.m1_readdatavalid = bus.s_readdatavalid & w_busy &  r_owner;
    assign bus.m0_readdata      = bus.s_readdata;
    assign bus.m1_readdata      = bus.s_readdata;

    assign bus.grant = w_busy ? {r_owner, ~r_owner} : 2'b00;
    assign bus.err   = r_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_owner <= 1'b0;
            r_last  <= 1'b1;
            r_err   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            if (w_err_set) begin
                r_err <= 1'b1;
            end else if (bus.err_clr) begin
                r_err <= 1'b0;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_req0 | w_req1) begin
                        r_owner <= w_winner;
                        r_last  <= w_winner;
                        r_state <= ST_CMD;
                    end
                end
                ST_CMD: begin
                    // An owner that withdraws mid-command loses the bus rather than stalling it.
                    if (!w_own_req) begin
                        r_state <= ST_IDLE;
                    end else if (!bus.s_waitrequest) begin
                        if (w_own_wr || bus.s_readdatavalid) begin
                            r_state <= ST_IDLE;
                        end else begin
                            r_state <= ST_RD_WAIT;
                            r_cnt   <= '0;
                        end
                    end
                end
                ST_RD_WAIT: begin
                    if (bus.s_readdatavalid || w_timeout) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end
endmodule
